// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, FSM state enums and the latched address-channel control fields.
package axi3_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    WrIdle,
    WrData,
    WrResp
  } wr_state_e;

  typedef enum logic {
    RdIdle,
    RdData
  } rd_state_e;

  typedef struct packed {
    logic [3:0] len;
    logic [2:0] size;
    axi_burst_e burst;
  } axi_ctrl_t;

endpackage

// File: rtl/axi3_mem_responder_if.sv
// AXI3 bus bundle (no lock/cache/prot/qos) between a master and the memory responder.
interface axi3_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 6
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi3_burst_addr_gen.sv
// Combinational AXI3 next-beat address for FIXED, INCR and WRAP bursts.
module axi3_burst_addr_gen
  import axi3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            len_i,
  input  logic [2:0]            size_i,
  input  axi_burst_e            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size_i;
    // Window is (len+1) beats of the transfer size, aligned to its own size.
    wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    incr_addr = addr_i + step;
    case (burst_i)
      BurstFixed: next_addr_o = addr_i;
      BurstWrap:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi3_mem_responder.sv
// AXI3 slave memory model: independent single-outstanding write and read engines over
// a word array based at BASE_ADDR.
module axi3_mem_responder
  import axi3_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 6,
  parameter int unsigned           MEM_ELS    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000)
) (
  input logic                 s00_axi_aclk,
  input logic                 s00_axi_aresetn,
  axi3_mem_responder_if.slave s00_axi
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned OffsBits = $clog2(StrbW);
  localparam int unsigned IdxW     = $clog2(MEM_ELS);
  localparam logic [ADDR_WIDTH-1:0] MemWords = ADDR_WIDTH'(MEM_ELS);

  logic [DATA_WIDTH-1:0] mem_q [MEM_ELS];
  logic                  rst_done_q;

  wr_state_e             w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next_addr, w_word;
  axi_ctrl_t             w_ctrl_q, w_ctrl_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic                  w_oob, w_last_beat, mem_we;
  logic [IdxW-1:0]       w_idx;

  rd_state_e             r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr, r_word;
  axi_ctrl_t             r_ctrl_q, r_ctrl_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic                  r_oob, r_last_beat;
  logic [IdxW-1:0]       r_idx;

  assign w_word      = (w_addr_q - BASE_ADDR) >> OffsBits;
  assign w_oob       = (w_addr_q < BASE_ADDR) || (w_word >= MemWords);
  assign w_idx       = w_word[IdxW-1:0];
  assign w_last_beat = (w_cnt_q == w_ctrl_q.len);

  assign r_word      = (r_addr_q - BASE_ADDR) >> OffsBits;
  assign r_oob       = (r_addr_q < BASE_ADDR) || (r_word >= MemWords);
  assign r_idx       = r_word[IdxW-1:0];
  assign r_last_beat = (r_cnt_q == r_ctrl_q.len);

  axi3_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .len_i       (w_ctrl_q.len),
    .size_i      (w_ctrl_q.size),
    .burst_i     (w_ctrl_q.burst),
    .next_addr_o (w_next_addr)
  );

  axi3_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_r_addr_gen (
    .addr_i      (r_addr_q),
    .len_i       (r_ctrl_q.len),
    .size_i      (r_ctrl_q.size),
    .burst_i     (r_ctrl_q.burst),
    .next_addr_o (r_next_addr)
  );

  // Ready outputs stay low until the first clock edge after reset release.
  assign s00_axi.awready = rst_done_q && (w_state_q == WrIdle);
  assign s00_axi.wready  = (w_state_q == WrData);
  assign s00_axi.bvalid  = (w_state_q == WrResp);
  assign s00_axi.bid     = s00_axi.bvalid ? w_id_q : '0;
  assign s00_axi.bresp   = (s00_axi.bvalid && w_err_q) ? RespSlverr : RespOkay;

  assign s00_axi.arready = rst_done_q && (r_state_q == RdIdle);
  assign s00_axi.rvalid  = (r_state_q == RdData);
  assign s00_axi.rid     = s00_axi.rvalid ? r_id_q : '0;
  assign s00_axi.rlast   = s00_axi.rvalid && r_last_beat;
  assign s00_axi.rdata   = (s00_axi.rvalid && !r_oob) ? mem_q[r_idx] : '0;
  assign s00_axi.rresp   = (s00_axi.rvalid && (r_oob || r_ctrl_q.burst == BurstRsvd)) ?
                           RespSlverr : RespOkay;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_ctrl_d  = w_ctrl_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WrIdle: begin
        if (s00_axi.awvalid && s00_axi.awready) begin
          w_id_d    = s00_axi.awid;
          w_addr_d  = s00_axi.awaddr;
          w_ctrl_d  = '{len: s00_axi.awlen, size: s00_axi.awsize,
                        burst: axi_burst_e'(s00_axi.awburst)};
          w_cnt_d   = 4'd0;
          w_err_d   = (s00_axi.awburst == BurstRsvd);
          w_state_d = WrData;
        end
      end
      WrData: begin
        if (s00_axi.wvalid) begin
          mem_we   = !w_oob;
          // Beat count ends the burst; a misplaced wlast only flags the response.
          w_err_d  = w_err_q || w_oob || (s00_axi.wid != w_id_q) ||
                     (s00_axi.wlast != w_last_beat);
          w_addr_d = w_next_addr;
          w_cnt_d  = w_cnt_q + 4'd1;
          if (w_last_beat) w_state_d = WrResp;
        end
      end
      WrResp: begin
        if (s00_axi.bready) w_state_d = WrIdle;
      end
      default: w_state_d = WrIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_ctrl_d  = r_ctrl_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      RdIdle: begin
        if (s00_axi.arvalid && s00_axi.arready) begin
          r_id_d    = s00_axi.arid;
          r_addr_d  = s00_axi.araddr;
          r_ctrl_d  = '{len: s00_axi.arlen, size: s00_axi.arsize,
                        burst: axi_burst_e'(s00_axi.arburst)};
          r_cnt_d   = 4'd0;
          r_state_d = RdData;
        end
      end
      RdData: begin
        if (s00_axi.rready) begin
          r_addr_d = r_next_addr;
          r_cnt_d  = r_cnt_q + 4'd1;
          if (r_last_beat) r_state_d = RdIdle;
        end
      end
      default: r_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rst_done_q <= 1'b0;
      w_state_q  <= WrIdle;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_ctrl_q   <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      r_state_q  <= RdIdle;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_ctrl_q   <= '0;
      r_cnt_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_ctrl_q   <= w_ctrl_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_ctrl_q   <= r_ctrl_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  // Backing store is deliberately not reset so contents survive a mid-burst reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (s00_axi.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= s00_axi.wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi3_mem_responder.sv
// Randomised bench for axi3_mem_responder against a byte-lane reference memory.
module tb_axi3_mem_responder;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          MEM_ELS = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] ref_mem [int];
  logic [63:0] wbeat_data [16];
  logic [7:0]  wbeat_strb [16];
  logic        wbeat_last [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [5:0]  rd_id [16];
  int          nbeats, stall_viol, first_lat;
  logic        rvalid_after;
  logic [5:0]  got_bid;
  logic [1:0]  got_bresp;

  axi3_mem_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(6)) bus ();

  axi3_mem_responder #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (32),
    .ID_WIDTH   (6),
    .MEM_ELS    (MEM_ELS),
    .BASE_ADDR  (BASE)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (bus)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input logic [1:0] burst, input int k);
    longint unsigned s, bytes, total, base;
    s = start; bytes = 64'd1 << size; total = longint'(len + 1) * bytes;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      base = (s / total) * total;
      return 32'(base + ((s - base) + longint'(k) * bytes) % total);
    end
    return 32'(s + longint'(k) * bytes);
  endfunction

  function automatic bit in_mem(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 8 < MEM_ELS);
  endfunction

  task automatic model_write(input logic [31:0] start, input int len, input logic [1:0] burst,
                             input logic [5:0] id, input logic [5:0] wid, output logic [1:0] exp);
    bit err; logic [31:0] a; logic [63:0] w; int idx;
    err = (burst == 2'b11) || (wid != id);
    for (int k = 0; k <= len; k++) begin
      if (wbeat_last[k] != (k == len)) err = 1;
      a = beat_addr(start, len, 3, burst, k);
      if (!in_mem(a)) err = 1;
      else begin
        idx = int'((a - BASE) / 8);
        w = ref_mem.exists(idx) ? ref_mem[idx] : 64'h0;
        for (int b = 0; b < 8; b++) if (wbeat_strb[k][b]) w[b*8 +: 8] = wbeat_data[k][b*8 +: 8];
        ref_mem[idx] = w;
      end
    end
    exp = err ? 2'b10 : 2'b00;
  endtask

  task automatic exp_beat(input logic [31:0] start, input int len, input logic [1:0] burst,
                          input int k, output logic [63:0] d, output logic [1:0] r);
    logic [31:0] a;
    a = beat_addr(start, len, 3, burst, k);
    if (in_mem(a)) begin
      d = ref_mem[int'((a - BASE) / 8)];
      r = (burst == 2'b11) ? 2'b10 : 2'b00;
    end else begin
      d = 64'h0; r = 2'b10;
    end
  endtask

  // ---------------- bus drivers (drive and sample on negedge) ----------------
  task automatic fill_beats(input int len, input bit rand_strb);
    for (int k = 0; k < 16; k++) begin
      wbeat_data[k] = {$urandom, $urandom};
      wbeat_strb[k] = rand_strb ? 8'($urandom) : 8'hFF;
      wbeat_last[k] = (k == len);
    end
  endtask

  task automatic aw_handshake(input logic [5:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len); bus.awsize = 3'd3;
    bus.awburst = burst; bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.awready !== 1'b1) begin errors++; $display("FAIL aw_timeout awready=%b required 1", bus.awready); end
    @(negedge clk); bus.awvalid = 1'b0;
  endtask

  task automatic ar_handshake(input logic [5:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = 4'(len); bus.arsize = 3'd3;
    bus.arburst = burst; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.arready !== 1'b1) begin errors++; $display("FAIL ar_timeout arready=%b required 1", bus.arready); end
    @(negedge clk); bus.arvalid = 1'b0;
  endtask

  task automatic w_beat(input int k, input logic [5:0] wid);
    int n = 0;
    bus.wid = wid; bus.wdata = wbeat_data[k]; bus.wstrb = wbeat_strb[k];
    bus.wlast = wbeat_last[k]; bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [5:0] wid);
    int n = 0;
    aw_handshake(id, addr, len, burst);
    for (int k = 0; k <= len; k++) w_beat(k, wid);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    got_bid = bus.bvalid ? bus.bid : 6'bx;
    got_bresp = bus.bvalid ? bus.bresp : 2'bx;
    @(negedge clk); bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [3:0] pat);
    logic [63:0] hd; logic [5:0] hid; logic hl; bit stalled; int cyc;
    ar_handshake(id, addr, len, burst);
    nbeats = 0; stall_viol = 0; first_lat = -1; stalled = 0; cyc = 0;
    while (nbeats <= len && cyc < 400) begin
      bus.rready = pat[cyc % 4];
      if (stalled && (bus.rvalid !== 1'b1 || bus.rdata !== hd || bus.rid !== hid || bus.rlast !== hl))
        stall_viol++;
      if (bus.rvalid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (bus.rvalid === 1'b1 && bus.rready) begin
        rd_data[nbeats] = bus.rdata; rd_resp[nbeats] = bus.rresp;
        rd_last[nbeats] = bus.rlast; rd_id[nbeats] = bus.rid; nbeats++;
      end
      stalled = (bus.rvalid === 1'b1) && !bus.rready;
      hd = bus.rdata; hid = bus.rid; hl = bus.rlast;
      @(negedge clk); cyc++;
    end
    bus.rready = 1'b0;
    rvalid_after = bus.rvalid;
  endtask

  // Compares every beat of the last read against the model.
  task automatic check_read(input string name, input logic [5:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] burst);
    logic [63:0] d; logic [1:0] r;
    checks++;
    if (nbeats != len + 1) begin errors++; $display("FAIL %s_beats got=%0d required=%0d", name, nbeats, len + 1); end
    for (int k = 0; k < nbeats && k <= len; k++) begin
      exp_beat(addr, len, burst, k, d, r);
      checks++;
      if (rd_data[k] !== d || rd_resp[k] !== r || rd_last[k] !== (k == len) || rd_id[k] !== id) begin
        errors++;
        $display("FAIL %s_beat%0d got data=%h resp=%b last=%b id=%h required data=%h resp=%b last=%b id=%h",
                 name, k, rd_data[k], rd_resp[k], rd_last[k], rd_id[k], d, r, (k == len), id);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=00000",
               {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.awready !== 1'b0) begin errors++; $display("FAIL reset_awready_early got=%b required=0", bus.awready); end
    @(negedge clk);
    checks++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after got=%b%b required=11", bus.awready, bus.arready);
    end
  endtask

  task automatic test_init();
    logic [1:0] exp;
    fill_beats(15, 0);
    do_write(6'h11, BASE, 15, 2'b01, 6'h11);
    model_write(BASE, 15, 2'b01, 6'h11, 6'h11, exp);
    checks++;
    if (got_bresp !== exp || got_bid !== 6'h11) begin
      errors++; $display("FAIL init_b got resp=%b id=%h required resp=%b id=11", got_bresp, got_bid, exp);
    end
    fill_beats(0, 0);
    do_write(6'h12, BASE + 32'((MEM_ELS - 1) * 8), 0, 2'b01, 6'h12);
    model_write(BASE + 32'((MEM_ELS - 1) * 8), 0, 2'b01, 6'h12, 6'h12, exp);
  endtask

  task automatic test_single();
    logic [5:0] id;
    logic [1:0] exp;
    id = 6'($urandom);
    fill_beats(0, 0);
    wbeat_data[0] = 64'hDEAD_BEEF_0123_4567;
    do_write(id, 32'h8000_0010, 0, 2'b01, id);
    model_write(32'h8000_0010, 0, 2'b01, id, id, exp);
    checks++;
    if (got_bresp !== 2'b00 || got_bid !== id) begin
      errors++; $display("FAIL single_b got resp=%b id=%h required resp=00 id=%h", got_bresp, got_bid, id);
    end
    do_read(id ^ 6'h3F, 32'h8000_0010, 0, 2'b01, 4'hF);
    checks++;
    if (rd_data[0] !== 64'hDEAD_BEEF_0123_4567 || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL single_r got data=%h last=%b resp=%b required deadbeef01234567/1/00",
                         rd_data[0], rd_last[0], rd_resp[0]);
    end
    checks++;
    if (first_lat != 0 || rd_id[0] !== (id ^ 6'h3F)) begin
      errors++; $display("FAIL single_latency got lat=%0d rid=%h required lat=0 rid=%h", first_lat, rd_id[0], id ^ 6'h3F);
    end
  endtask

  task automatic test_incr_strobe();
    logic [1:0] exp; logic [63:0] w2;
    fill_beats(3, 0);
    for (int k = 0; k < 4; k++) wbeat_data[k] = 64'(k) | 64'hFFFF_FFFF_0000_0000;
    wbeat_strb[2] = 8'h0F;
    w2 = {ref_mem[2][63:32], 32'h2};
    do_write(6'h05, BASE, 3, 2'b01, 6'h05);
    model_write(BASE, 3, 2'b01, 6'h05, 6'h05, exp);
    do_read(6'h06, BASE, 3, 2'b01, 4'hF);
    checks++;
    if (rd_data[2] !== w2) begin errors++; $display("FAIL strobe_word2 got=%h required=%h", rd_data[2], w2); end
    check_read("incr", 6'h06, BASE, 3, 2'b01);
  endtask

  task automatic test_wrap();
    logic [1:0] exp;
    fill_beats(3, 0);
    do_write(6'h07, 32'h8000_0018, 3, 2'b10, 6'h07);
    model_write(32'h8000_0018, 3, 2'b10, 6'h07, 6'h07, exp);
    do_read(6'h08, BASE, 3, 2'b01, 4'hF);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data[(3 + k) % 4] !== wbeat_data[k]) begin
        errors++; $display("FAIL wrap_beat%0d got=%h required=%h", k, rd_data[(3 + k) % 4], wbeat_data[k]);
      end
    end
    do_read(6'h09, 32'h8000_0010, 3, 2'b10, 4'hF);
    check_read("wrap_rd", 6'h09, 32'h8000_0010, 3, 2'b10);
  endtask

  task automatic test_backpressure();
    do_read(6'h2A, BASE, 7, 2'b01, 4'b1001);
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d violations required=0", stall_viol); end
    checks++;
    if (rvalid_after !== 1'b0) begin errors++; $display("FAIL bp_extra_rvalid got=%b required=0", rvalid_after); end
    check_read("bp", 6'h2A, BASE, 7, 2'b01);
  endtask

  task automatic test_errors();
    logic [1:0] exp;
    logic [31:0] top;
    top = BASE + 32'((MEM_ELS - 1) * 8);
    fill_beats(0, 0);
    do_write(6'h01, BASE + 32'(MEM_ELS * 8), 0, 2'b01, 6'h01);
    model_write(BASE + 32'(MEM_ELS * 8), 0, 2'b01, 6'h01, 6'h01, exp);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL err_oob_write got=%b required=10", got_bresp); end
    do_read(6'h02, top, 0, 2'b01, 4'hF);
    check_read("err_top_unchanged", 6'h02, top, 0, 2'b01);
    fill_beats(1, 0);
    do_write(6'h03, top, 1, 2'b01, 6'h03);
    model_write(top, 1, 2'b01, 6'h03, 6'h03, exp);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL err_straddle got=%b required=10", got_bresp); end
    do_read(6'h04, top, 1, 2'b01, 4'hF);
    check_read("err_oob_read", 6'h04, top, 1, 2'b01);
    fill_beats(3, 0);
    wbeat_last[1] = 1'b1; wbeat_last[3] = 1'b0;
    do_write(6'h0A, BASE + 32'd32, 3, 2'b01, 6'h0A);
    model_write(BASE + 32'd32, 3, 2'b01, 6'h0A, 6'h0A, exp);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL err_wlast got=%b required=10", got_bresp); end
    do_read(6'h0B, BASE + 32'd32, 3, 2'b01, 4'hF);
    check_read("err_wlast_data", 6'h0B, BASE + 32'd32, 3, 2'b01);
    fill_beats(0, 0);
    do_write(6'h0C, BASE + 32'd64, 0, 2'b01, 6'h0D);
    model_write(BASE + 32'd64, 0, 2'b01, 6'h0C, 6'h0D, exp);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL err_wid got=%b required=10", got_bresp); end
    fill_beats(1, 0);
    do_write(6'h0E, BASE + 32'd72, 1, 2'b11, 6'h0E);
    model_write(BASE + 32'd72, 1, 2'b11, 6'h0E, 6'h0E, exp);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL err_rsvd_write got=%b required=10", got_bresp); end
    do_read(6'h0F, BASE + 32'd72, 1, 2'b11, 4'hF);
    check_read("err_rsvd_read", 6'h0F, BASE + 32'd72, 1, 2'b11);
    do_read(6'h10, BASE - 32'd8, 0, 2'b01, 4'hF);
    check_read("err_below_base", 6'h10, BASE - 32'd8, 0, 2'b01);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [1:0] burst, exp; int len, sw; logic [5:0] id; logic [31:0] addr;
      burst = 2'($urandom_range(0, 2));
      len = (burst == 2'b10) ? ((1 << $urandom_range(1, 2)) - 1) : int'($urandom_range(0, 3));
      sw = (burst == 2'b01) ? int'($urandom_range(0, 15 - len)) : int'($urandom_range(0, 15));
      addr = BASE + 32'(sw * 8);
      id = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        fill_beats(len, 1);
        do_write(id, addr, len, burst, id);
        model_write(addr, len, burst, id, id, exp);
        checks++;
        if (got_bresp !== exp || got_bid !== id) begin
          errors++; $display("FAIL rand_b%0d got resp=%b id=%h required resp=%b id=%h", it, got_bresp, got_bid, exp, id);
        end
      end else begin
        do_read(id, addr, len, burst, 4'($urandom) | 4'b0001);
        check_read("rand_rd", id, addr, len, burst);
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL rand_stable%0d got=%0d required=0", it, stall_viol); end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_beats(7, 0);
    aw_handshake(6'h33, BASE, 7, 2'b01);
    w_beat(0, 6'h33);
    w_beat(1, 6'h33);
    ref_mem[0] = wbeat_data[0];
    ref_mem[1] = wbeat_data[1];
    bus.wid = 6'h33; bus.wdata = wbeat_data[2]; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wready, bus.bvalid, bus.rvalid, bus.awready} !== 4'b0) begin
      errors++; $display("FAIL midrst_async got=%b required=0000", {bus.wready, bus.bvalid, bus.rvalid, bus.awready});
    end
    bus.wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.awready !== 1'b0) begin errors++; $display("FAIL midrst_awready_early got=%b required=0", bus.awready); end
    @(negedge clk);
    checks++;
    if (bus.awready !== 1'b1) begin errors++; $display("FAIL midrst_awready got=%b required=1", bus.awready); end
    do_read(6'h34, BASE, 7, 2'b01, 4'hF);
    check_read("midrst_data", 6'h34, BASE, 7, 2'b01);
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_init();
    test_single();
    test_incr_strobe();
    test_wrap();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
